// File: rtl/seq_miter_cmp.sv
// ---------------------------------------------------------------------------
// seq_miter_cmp
//
// Clocked, multi-channel gold/gate miter. CHANNELS pairs of WIDTH-bit vectors
// are sampled into a register stage, compared with don't-care masking in the
// next stage, and the verdict is committed into sticky per-channel failure
// flags, saturating sample/error counters and a first-mismatch record.
//
// Intended to sit beside gate-level partitions in simulation and emulation,
// where formal equivalence checks are unavailable.
//
// Parameters
//   WIDTH          bits per channel
//   CHANNELS       number of gold/gate pairs
//   CNT_W          width of sample_cnt, err_cnt and first_idx
//   SETTLE_CYCLES  valid samples skipped after start before checking (0 ok)
//   STOP_ON_FAIL   1 = freeze on first mismatch, 0 = keep checking
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          pulse, arms the checker (accepted in IDLE and FAIL)
//   stop           pulse, SETTLE/CHECK -> IDLE, results held
//   clear          synchronous clear of results, state and pipeline
//   in_valid       gold/gate/gold_dc qualify this cycle
//   gold, gate     packed vectors, channel c at [c*WIDTH +: WIDTH]
//   gold_dc        1 = bit is don't-care
//   busy           state is SETTLE or CHECK
//   fail           OR of ch_fail
//   ch_fail        sticky per-channel mismatch
//   first_ch       channel of the first mismatch (lowest index on ties)
//   first_idx      sample index of the first mismatch
//   first_vld      first_ch / first_idx are valid
//   sample_cnt     compared samples, saturating
//   err_cnt        samples with at least one failing channel, saturating
// ---------------------------------------------------------------------------
module seq_miter_cmp #(
   parameter int WIDTH         = 1,
   parameter int CHANNELS      = 4,
   parameter int CNT_W         = 16,
   parameter int SETTLE_CYCLES = 2,
   parameter int STOP_ON_FAIL  = 1,
   localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        clear,
   input  logic                        in_valid,
   input  logic [CHANNELS*WIDTH-1:0]   gold,
   input  logic [CHANNELS*WIDTH-1:0]   gate,
   input  logic [CHANNELS*WIDTH-1:0]   gold_dc,
   output logic                        busy,
   output logic                        fail,
   output logic [CHANNELS-1:0]         ch_fail,
   output logic [CH_W-1:0]             first_ch,
   output logic [CNT_W-1:0]            first_idx,
   output logic                        first_vld,
   output logic [CNT_W-1:0]            sample_cnt,
   output logic [CNT_W-1:0]            err_cnt
);

   localparam int VEC_W = CHANNELS * WIDTH;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Last settle count before entering CHECK. Unused when SETTLE_CYCLES=0,
   // since SETTLE is then never entered.
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [1:0] ST_FAIL   = 2'd3;

   // Where an accepted start lands.
   localparam logic [1:0] ST_ARMED  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

   logic [1:0]       state;
   logic [SET_W-1:0] settle_cnt;

   // Stage 1: registered sample.
   logic             s1_vld;
   logic [VEC_W-1:0] s1_gold;
   logic [VEC_W-1:0] s1_gate;
   logic [VEC_W-1:0] s1_dc;

   // Stage 2: combinational verdict on the stage-1 sample.
   logic [CHANNELS-1:0] miss;
   logic                any_miss;
   logic [CH_W-1:0]     low_ch;

   logic capture;
   logic commit;
   logic accept_start;

   assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
   assign fail = |ch_fail;

   // Samples are only taken while actively checking.
   assign capture = (state == ST_CHECK) && in_valid;

   // A sample already in stage 1 is committed even if stop has moved the
   // state to IDLE; only a frozen (FAIL) checker discards it.
   assign commit = s1_vld && (state != ST_FAIL);

   assign accept_start = start && ((state == ST_IDLE) || (state == ST_FAIL));

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   // NOTE: sequential state is assigned with non-blocking (<=) so every
   // register samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
      end else if (clear) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
      end else if (stop && busy) begin
         state      <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_FAIL: begin
               if (start) begin
                  state      <= ST_ARMED;
                  settle_cnt <= '0;
               end
            end
            ST_SETTLE: begin
               // Only valid cycles count towards settling.
               if (in_valid) begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= ST_CHECK;
                  end else begin
                     settle_cnt <= settle_cnt + SET_W'(1);
                  end
               end
            end
            ST_CHECK: begin
               if (commit && any_miss && (STOP_ON_FAIL != 0)) begin
                  state <= ST_FAIL;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Stage 1
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= capture && !clear;
      end
   end

   // NOTE: the sample data registers carry no reset; they are only ever
   // observed through s1_vld, which is reset, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (capture) begin
         s1_gold <= gold;
         s1_gate <= gate;
         s1_dc   <= gold_dc;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: masked compare
   // ------------------------------------------------------------------------
   // NOTE: every variable written in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      miss = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         miss[c] = |((s1_gold[c*WIDTH +: WIDTH] ^ s1_gate[c*WIDTH +: WIDTH])
                     & ~s1_dc[c*WIDTH +: WIDTH]);
      end
   end

   assign any_miss = |miss;

   // Lowest failing channel: scan downwards so the lowest index wins.
   always_comb begin
      low_ch = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (miss[c]) begin
            low_ch = CH_W'(c);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Results
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_fail    <= '0;
         first_ch   <= '0;
         first_idx  <= '0;
         first_vld  <= 1'b0;
         sample_cnt <= '0;
         err_cnt    <= '0;
      end else if (clear || accept_start) begin
         // Re-arming wipes the previous run; a commit on the same edge is
         // part of the old run and is dropped.
         ch_fail    <= '0;
         first_ch   <= '0;
         first_idx  <= '0;
         first_vld  <= 1'b0;
         sample_cnt <= '0;
         err_cnt    <= '0;
      end else if (commit) begin
         if (sample_cnt != CNT_MAX) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
         end
         if (any_miss) begin
            if (err_cnt != CNT_MAX) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
            ch_fail <= ch_fail | miss;
            if (!first_vld) begin
               // Index is the count before this sample, already saturated.
               first_ch  <= low_ch;
               first_idx <= sample_cnt;
               first_vld <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_miter_cmp.sv
// ---------------------------------------------------------------------------
// tb_seq_miter_cmp
//
// Three checker instances share one stimulus stream:
//   a: CNT_W=16, SETTLE_CYCLES=2, STOP_ON_FAIL=1
//   b: CNT_W=16, SETTLE_CYCLES=0, STOP_ON_FAIL=0
//   c: CNT_W=3,  SETTLE_CYCLES=2, STOP_ON_FAIL=0
// A behavioural model per instance predicts every output; a compare process
// checks all instances on each falling edge, and directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seq_miter_cmp;

   localparam int W  = 8;
   localparam int CH = 4;

   localparam int M_IDLE   = 0;
   localparam int M_SETTLE = 1;
   localparam int M_CHECK  = 2;
   localparam int M_FAIL   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] gold = '0;
   logic [31:0] gate = '0;
   logic [31:0] gold_dc = '0;

   logic        a_busy, a_fail, a_vld;
   logic [3:0]  a_chf;
   logic [1:0]  a_fch;
   logic [15:0] a_fidx, a_sc, a_ec;

   logic        b_busy, b_fail, b_vld;
   logic [3:0]  b_chf;
   logic [1:0]  b_fch;
   logic [15:0] b_fidx, b_sc, b_ec;

   logic        c_busy, c_fail, c_vld;
   logic [3:0]  c_chf;
   logic [1:0]  c_fch;
   logic [2:0]  c_fidx, c_sc, c_ec;

   int n_cmp = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   seq_miter_cmp #(.WIDTH(W), .CHANNELS(CH), .CNT_W(16), .SETTLE_CYCLES(2), .STOP_ON_FAIL(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
      .in_valid(in_valid), .gold(gold), .gate(gate), .gold_dc(gold_dc),
      .busy(a_busy), .fail(a_fail), .ch_fail(a_chf), .first_ch(a_fch),
      .first_idx(a_fidx), .first_vld(a_vld), .sample_cnt(a_sc), .err_cnt(a_ec));

   seq_miter_cmp #(.WIDTH(W), .CHANNELS(CH), .CNT_W(16), .SETTLE_CYCLES(0), .STOP_ON_FAIL(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
      .in_valid(in_valid), .gold(gold), .gate(gate), .gold_dc(gold_dc),
      .busy(b_busy), .fail(b_fail), .ch_fail(b_chf), .first_ch(b_fch),
      .first_idx(b_fidx), .first_vld(b_vld), .sample_cnt(b_sc), .err_cnt(b_ec));

   seq_miter_cmp #(.WIDTH(W), .CHANNELS(CH), .CNT_W(3), .SETTLE_CYCLES(2), .STOP_ON_FAIL(0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
      .in_valid(in_valid), .gold(gold), .gate(gate), .gold_dc(gold_dc),
      .busy(c_busy), .fail(c_fail), .ch_fail(c_chf), .first_ch(c_fch),
      .first_idx(c_fidx), .first_vld(c_vld), .sample_cnt(c_sc), .err_cnt(c_ec));

   // ------------------------------------------------------------------------
   // Behavioural model, one slot per instance
   // ------------------------------------------------------------------------
   int        m_mode [3];
   int        m_seen [3];
   int        m_sc   [3];
   int        m_ec   [3];
   int        m_fch  [3];
   int        m_fidx [3];
   bit        m_fvld [3];
   bit [3:0]  m_chf  [3];
   bit        m_pv   [3];   // a sample waiting to be judged
   bit [3:0]  m_pm   [3];   // its per-channel verdict

   function automatic int settle_of(input int i);
      return (i == 1) ? 0 : 2;
   endfunction

   function automatic bit stop_of(input int i);
      return (i == 0);
   endfunction

   function automatic int max_of(input int i);
      return (i == 2) ? 7 : 65535;
   endfunction

   function automatic bit [3:0] miss_of(input logic [31:0] g, t, d);
      logic [31:0] x;
      bit [3:0]    m;
      x = (g ^ t) & ~d;
      for (int c = 0; c < CH; c++) m[c] = (x[c*W +: W] != 8'd0);
      return m;
   endfunction

   function automatic int lowest(input bit [3:0] m);
      for (int c = 0; c < CH; c++) if (m[c]) return c;
      return 0;
   endfunction

   task automatic model_results_zero(input int i);
      m_sc[i] = 0; m_ec[i] = 0; m_fch[i] = 0; m_fidx[i] = 0;
      m_fvld[i] = 1'b0; m_chf[i] = 4'd0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         model_results_zero(i);
         m_mode[i] = M_IDLE; m_seen[i] = 0; m_pv[i] = 1'b0; m_pm[i] = 4'd0;
      end
   endtask

   // Advance instance i by one clock edge using the inputs present at it.
   task automatic model_step(input int i);
      int       old;
      bit       cap_v;
      bit [3:0] cap_m;
      bit       hit;
      old   = m_mode[i];
      cap_v = (old == M_CHECK) && in_valid;
      cap_m = miss_of(gold, gate, gold_dc);
      hit   = 1'b0;
      if (clear) begin
         model_results_zero(i);
         m_mode[i] = M_IDLE; m_seen[i] = 0; m_pv[i] = 1'b0;
         return;
      end
      if (m_pv[i] && old != M_FAIL) begin
         if (m_pm[i] != 4'd0) begin
            hit = 1'b1;
            if (!m_fvld[i]) begin
               m_fch[i]  = lowest(m_pm[i]);
               m_fidx[i] = m_sc[i];
               m_fvld[i] = 1'b1;
            end
            m_ec[i]  = (m_ec[i] < max_of(i)) ? m_ec[i] + 1 : m_ec[i];
            m_chf[i] = m_chf[i] | m_pm[i];
         end
         m_sc[i] = (m_sc[i] < max_of(i)) ? m_sc[i] + 1 : m_sc[i];
      end
      if (stop && (old == M_SETTLE || old == M_CHECK)) begin
         m_mode[i] = M_IDLE;
      end else if (start && (old == M_IDLE || old == M_FAIL)) begin
         model_results_zero(i);
         m_mode[i] = (settle_of(i) == 0) ? M_CHECK : M_SETTLE;
         m_seen[i] = 0;
      end else if (old == M_SETTLE && in_valid) begin
         m_seen[i]++;
         if (m_seen[i] == settle_of(i)) m_mode[i] = M_CHECK;
      end else if (old == M_CHECK && hit && stop_of(i)) begin
         m_mode[i] = M_FAIL;
      end
      m_pv[i] = cap_v;
      m_pm[i] = cap_m;
   endtask

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic bz, input logic fl, input logic [3:0] cf,
                           input logic [1:0] fc, input logic [15:0] fi, input logic [15:0] s,
                           input logic [15:0] e, input logic fv);
      check($sformatf("i%0d.busy", i), 64'(bz), 64'(m_mode[i] == M_SETTLE || m_mode[i] == M_CHECK));
      check($sformatf("i%0d.fail", i), 64'(fl), 64'(m_chf[i] != 4'd0));
      check($sformatf("i%0d.ch_fail", i), 64'(cf), 64'(m_chf[i]));
      check($sformatf("i%0d.first_ch", i), 64'(fc), 64'(m_fch[i]));
      check($sformatf("i%0d.first_idx", i), 64'(fi), 64'(m_fidx[i]));
      check($sformatf("i%0d.first_vld", i), 64'(fv), 64'(m_fvld[i]));
      check($sformatf("i%0d.sample_cnt", i), 64'(s), 64'(m_sc[i]));
      check($sformatf("i%0d.err_cnt", i), 64'(e), 64'(m_ec[i]));
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_inst(0, a_busy, a_fail, a_chf, a_fch, a_fidx, a_sc, a_ec, a_vld);
         cmp_inst(1, b_busy, b_fail, b_chf, b_fch, b_fidx, b_sc, b_ec, b_vld);
         cmp_inst(2, c_busy, c_fail, c_chf, c_fch, {13'd0, c_fidx}, {13'd0, c_sc},
                  {13'd0, c_ec}, c_vld);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic step(input logic st, input logic sp, input logic cl, input logic v,
                       input logic [31:0] g, input logic [31:0] t, input logic [31:0] d);
      start = st; stop = sp; clear = cl; in_valid = v;
      gold = g; gate = t; gold_dc = d;
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      start = 1'b0; stop = 1'b0; clear = 1'b0; in_valid = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic smp(input logic [31:0] g, input logic [31:0] t, input logic [31:0] d);
      step(1'b0, 1'b0, 1'b0, 1'b1, g, t, d);
   endtask

   function automatic logic [31:0] gpat(input int k);
      return 32'h1234_5678 ^ (32'(k) * 32'h0101_0101);
   endfunction

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset.a_busy", 64'(a_busy), 0);
      check("reset.b_sample_cnt", 64'(b_sc), 0);
      check("reset.c_first_vld", 64'(c_vld), 0);
      #2 rst_n = 1'b1;

      // Pass path: 2 settle samples, then 8 compared.
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      check("t1.a_busy_after_start", 64'(a_busy), 1);
      for (int k = 0; k < 10; k++) smp(gpat(k), gpat(k), 32'h0);
      idle();
      check("t1.a_sample_cnt", 64'(a_sc), 8);
      check("t1.a_err_cnt", 64'(a_ec), 0);
      check("t1.a_fail", 64'(a_fail), 0);

      // First-mismatch capture at index 4, channel 2 bit 3.
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 6; k++) smp(gpat(k), gpat(k), 32'h0);
      smp(gpat(6), gpat(6) ^ 32'h0008_0000, 32'h0);
      smp(gpat(7), gpat(7) ^ 32'h0000_0001, 32'h0);
      check("t2.a_fail", 64'(a_fail), 1);
      check("t2.a_ch_fail", 64'(a_chf), 64'h4);
      check("t2.a_first_ch", 64'(a_fch), 2);
      check("t2.a_first_idx", 64'(a_fidx), 4);
      check("t2.a_busy_in_fail", 64'(a_busy), 0);
      smp(gpat(8), ~gpat(8), 32'h0);
      idle();
      check("t2.a_err_cnt_frozen", 64'(a_ec), 1);
      check("t2.a_sample_cnt_frozen", 64'(a_sc), 5);

      // Multi-channel and don't-care masking on instance b.
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      smp(gpat(9), gpat(9) ^ 32'h0100_2000, 32'h0000_2000);
      smp(gpat(10), gpat(10) ^ 32'h0100_2000, 32'h0);
      check("t3.b_ch_fail_masked", 64'(b_chf), 64'h8);
      check("t3.b_first_ch", 64'(b_fch), 3);
      check("t3.b_first_idx", 64'(b_fidx), 0);
      smp(gpat(11), ~gpat(11), 32'hFFFF_FFFF);
      idle();
      check("t3.b_ch_fail_unmasked", 64'(b_chf), 64'hA);
      check("t3.b_first_ch_held", 64'(b_fch), 3);
      check("t3.b_err_cnt", 64'(b_ec), 2);
      check("t3.b_sample_cnt", 64'(b_sc), 3);

      // Saturation on instance c (CNT_W=3).
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 14; k++) smp(gpat(k), ~gpat(k), 32'h0);
      idle();
      check("t4.c_sample_cnt_sat", 64'(c_sc), 7);
      check("t4.c_err_cnt_sat", 64'(c_ec), 7);
      check("t4.c_first_idx", 64'(c_fidx), 0);
      check("t4.c_ch_fail", 64'(c_chf), 64'hF);

      // clear beats start while a is in FAIL.
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      check("t5.a_busy_after_clear", 64'(a_busy), 0);
      check("t5.a_fail_after_clear", 64'(a_fail), 0);
      check("t5.a_sample_cnt_after_clear", 64'(a_sc), 0);
      check("t5.c_first_vld_after_clear", 64'(c_vld), 0);

      // first_idx captures a saturated count.
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 9; k++) smp(gpat(k), gpat(k), 32'h0);
      smp(gpat(20), gpat(20) ^ 32'h0000_0080, 32'h0);
      idle();
      check("t5.c_first_idx_sat", 64'(c_fidx), 7);
      check("t5.c_sample_cnt", 64'(c_sc), 7);
      check("t5.c_err_cnt", 64'(c_ec), 1);
      check("t5.b_sample_cnt", 64'(b_sc), 10);
      check("t5.b_first_idx", 64'(b_fidx), 9);
      check("t5.a_first_idx", 64'(a_fidx), 7);

      // stop with a sample in flight: still counted, then held.
      step(1'b0, 1'b1, 1'b0, 1'b1, gpat(30), gpat(30), 32'h0);
      check("t5.b_busy_after_stop", 64'(b_busy), 0);
      check("t5.b_sample_cnt_in_flight", 64'(b_sc), 10);
      idle();
      check("t5.b_sample_cnt_committed", 64'(b_sc), 11);
      idle();
      check("t5.b_sample_cnt_held", 64'(b_sc), 11);
      check("t5.b_err_cnt_held", 64'(b_ec), 1);

      // Asynchronous reset mid-CHECK with a sample in flight.
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) smp(gpat(k), ~gpat(k), 32'h0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("t6.b_sample_cnt_async", 64'(b_sc), 0);
      check("t6.b_busy_async", 64'(b_busy), 0);
      check("t6.b_fail_async", 64'(b_fail), 0);
      check("t6.a_ch_fail_async", 64'(a_chf), 0);
      check("t6.c_err_cnt_async", 64'(c_ec), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      idle();
      idle();
      check("t6.b_no_stale_commit", 64'(b_sc), 0);
      check("t6.b_err_cnt_after", 64'(b_ec), 0);
      check("t6.a_busy_after", 64'(a_busy), 0);

      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
